// File: rtl/l2_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// l2_rr_arbiter_if
// Bundles the L1-side request/response signals and the L2 port of the shared
// L2 arbiter.
//   slave  : arbiter view. It samples the requests and L2 returns, and drives
//            the responses and L2 strobes.
//   master : environment view. It covers the L1 caches and the L2 model.
// Parameters: ADDR_W (address width), LINE_W (cache line width).
// -----------------------------------------------------------------------------
interface l2_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // I-cache miss path (read-only)
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache miss/writeback path
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // L2 port
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface

// File: rtl/l2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// l2_rr_arbiter
// Shares the single L2 port between the I-cache miss path and the D-cache
// miss/writeback path.
// - It arbitrates between the two sides in round-robin order.
// - It latches the winner's address and write line.
// - It runs one L2 transaction at a time.
// - It returns the result to the winner as a one-cycle response pulse.
//
// Ports:
//   clk    : clock; all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : l2_rr_arbiter_if.slave, carrying these signals:
//            i_read/i_addr -> i_rdata/i_resp
//            d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp
//            l2_read/l2_write/l2_addr/l2_wdata <- l2_rdata/l2_resp
//
// Build option:
//   L2_ARB_FIXED_PRIO_EN : when defined, the I side always wins a tie. This is
//                          the legacy instruction-first policy, and no
//                          last-grant state is kept. When undefined, ties
//                          alternate between the two sides.
// -----------------------------------------------------------------------------
module l2_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  l2_rr_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_IRD = 3'd1,
    BUSY_DRD = 3'd2,
    BUSY_DWR = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_l2_read;
  logic              r_l2_write;
  logic [ADDR_W-1:0] r_l2_addr;
  logic [LINE_W-1:0] r_l2_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;

  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_d_req = bus.d_read | bus.d_write;

`ifdef L2_ARB_FIXED_PRIO_EN
  // Instruction-first: the I side wins whenever it asks.
  assign w_grant_i = bus.i_read;
`else
  // Set when the D side won the last grant, so the I side wins the next tie.
  logic r_last_grant_d;
  assign w_grant_i = bus.i_read & (~w_d_req | r_last_grant_d);
`endif
  assign w_grant_d = w_d_req & ~w_grant_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_l2_read  <= 1'b0;
      r_l2_write <= 1'b0;
      r_l2_addr  <= '0;
      r_l2_wdata <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_resp   <= 1'b0;
      r_d_resp   <= 1'b0;
`ifndef L2_ARB_FIXED_PRIO_EN
      r_last_grant_d <= 1'b1;
`endif
    end else begin
      // The response pulses last one cycle by default.
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_i || w_grant_d) begin
            r_l2_addr  <= w_grant_i ? bus.i_addr : bus.d_addr;
            r_l2_wdata <= bus.d_wdata;
`ifndef L2_ARB_FIXED_PRIO_EN
            r_last_grant_d <= w_grant_d;
`endif
            if (w_grant_i) begin
              r_state   <= BUSY_IRD;
              r_l2_read <= 1'b1;
            end else if (bus.d_write) begin
              // A D-side write takes precedence over a simultaneous D-side read.
              r_state    <= BUSY_DWR;
              r_l2_write <= 1'b1;
            end else begin
              r_state   <= BUSY_DRD;
              r_l2_read <= 1'b1;
            end
          end
        end
        BUSY_IRD: begin
          if (bus.l2_resp) begin
            r_i_rdata <= bus.l2_rdata;
            r_i_resp  <= 1'b1;
            r_l2_read <= 1'b0;
            r_state   <= RESP;
          end
        end
        BUSY_DRD: begin
          if (bus.l2_resp) begin
            r_d_rdata <= bus.l2_rdata;
            r_d_resp  <= 1'b1;
            r_l2_read <= 1'b0;
            r_state   <= RESP;
          end
        end
        BUSY_DWR: begin
          if (bus.l2_resp) begin
            r_d_resp   <= 1'b1;
            r_l2_write <= 1'b0;
            r_state    <= RESP;
          end
        end
        // Requests are deliberately not sampled here. They are arbitrated
        // in the next IDLE cycle.
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.l2_read  = r_l2_read;
  assign bus.l2_write = r_l2_write;
  assign bus.l2_addr  = r_l2_addr;
  assign bus.l2_wdata = r_l2_wdata;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.i_resp   = r_i_resp;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.d_resp   = r_d_resp;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_rr_arbiter
// Self-checking bench for l2_rr_arbiter. It uses two kinds of stimulus:
// - A table of request vectors. Each vector has its expected grant.
// - Hand-written sequences. These cover the mid-transaction reset and the
//   stray l2_resp cases.
// Expected responses go into a scoreboard queue when a request is granted.
// They are popped and compared when the DUT pulses i_resp or d_resp.
// -----------------------------------------------------------------------------
module tb_l2_rr_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef L2_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  l2_rr_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  l2_rr_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          ir;
    logic          dr;
    logic          dw;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] wd;
    logic [LW-1:0] l2d;
    int            lat;     // cycles between L2 strobe and l2_resp
    logic          mut;     // scramble requester inputs while busy
    logic          exp_d;   // expected winner is the D side
    logic          exp_wr;  // expected L2 write
  } vec_t;

  typedef struct {
    logic          to_d;
    logic [LW-1:0] i_rd;
    logic [LW-1:0] d_rd;
  } exp_t;

  vec_t          vecs [8];
  vec_t          vpost;
  exp_t          sb [$];
  logic [LW-1:0] exp_i_rd;
  logic [LW-1:0] exp_d_rd;
  int            checks = 0;
  int            errors = 0;
  int            txn    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bounded wait for a response pulse, then compare it with the scoreboard head.
  task automatic wait_resp();
    exp_t e;
    int   n = 0;
    while (!(bus.i_resp || bus.d_resp) && n < 20) begin
      tick();
      n++;
    end
    if (!(bus.i_resp || bus.d_resp)) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response expected one within 20 cycles");
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b expected none", bus.i_resp, bus.d_resp);
    end else begin
      e = sb.pop_front();
      chk("resp_side", {bus.i_resp, bus.d_resp}, e.to_d ? 2'b01 : 2'b10);
      chk("i_rdata", bus.i_rdata, e.i_rd);
      chk("d_rdata", bus.d_rdata, e.d_rd);
      $display("txn %0d: resp to %s i_rdata=%h d_rdata=%h",
               txn, e.to_d ? "D" : "I", bus.i_rdata[31:0], bus.d_rdata[31:0]);
      txn++;
    end
  endtask

  // Drive one vector, check the grant and the L2 side, then serve L2 and
  // collect the response. It is called either in IDLE or in the RESP cycle of
  // the previous transaction.
  task automatic run_vec(input vec_t v, input bit from_resp);
    exp_t          e;
    logic [AW-1:0] exp_addr;
    bus.i_read  = v.ir;
    bus.d_read  = v.dr;
    bus.d_write = v.dw;
    bus.i_addr  = v.ia;
    bus.d_addr  = v.da;
    bus.d_wdata = v.wd;
    if (from_resp) begin
      tick();  // RESP -> IDLE, requests not sampled
      chk("resp_single", {bus.i_resp, bus.d_resp}, 2'b00);
      chk("idle_no_strobe", {bus.l2_read, bus.l2_write}, 2'b00);
    end
    tick();    // IDLE sampled -> BUSY, strobe visible one cycle after the request
    exp_addr = v.exp_d ? v.da : v.ia;
    chk("grant_l2_read", bus.l2_read, !v.exp_wr);
    chk("grant_l2_write", bus.l2_write, v.exp_wr);
    chk("grant_l2_addr", bus.l2_addr, exp_addr);
    chk("grant_l2_wdata", bus.l2_wdata, v.wd);
    if (!v.exp_wr) begin
      if (v.exp_d) exp_d_rd = v.l2d;
      else         exp_i_rd = v.l2d;
    end
    e.to_d = v.exp_d;
    e.i_rd = exp_i_rd;
    e.d_rd = exp_d_rd;
    sb.push_back(e);
    for (int i = 0; i < v.lat; i++) begin
      if (v.mut) begin
        bus.d_wdata = '0;
        bus.d_addr  = '1;
        bus.i_addr  = '1;
      end
      tick();
      chk("busy_strobe", {bus.l2_read, bus.l2_write}, {!v.exp_wr, v.exp_wr});
      chk("busy_addr", bus.l2_addr, exp_addr);
      chk("busy_wdata", bus.l2_wdata, v.wd);
    end
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = v.l2d;
    tick();    // RESP
    bus.l2_resp  = 1'b0;
    bus.l2_rdata = {8{$urandom}};
    chk("resp_no_strobe", {bus.l2_read, bus.l2_write}, 2'b00);
    wait_resp();
  endtask

  initial begin
    //            ir dr dw ia          da          wd                l2d               lat mut exp_d         exp_wr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, {8{32'h0}},        {8{32'hA5A5A5A5}}, 2, 1'b0, 1'b0,          1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2000, {8{32'h12345678}}, {8{32'h0BAD0BAD}}, 2, 1'b1, 1'b1,          1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h3000, 32'h4000, {8{32'h0}},          {8{32'h11111111}}, 0, 1'b0, 1'b0,          1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h3040, 32'h4040, {8{32'h0}},          {8{32'h22222222}}, 1, 1'b0, FIXED ? 1'b0 : 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h3080, 32'h4080, {8{32'h0}},          {8{32'h33333333}}, 3, 1'b0, 1'b0,          1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h30C0, 32'h40C0, {8{32'h0}},          {8{32'h44444444}}, 1, 1'b0, FIXED ? 1'b0 : 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h5000, {8{32'hCCCCCCCC}},      {8{32'h55555555}}, 1, 1'b0, 1'b1,          1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h6100, 32'h6200, {8{32'hDDDDDDDD}},   {8{32'h66666666}}, 1, 1'b0, FIXED ? 1'b0 : 1'b0, 1'b0};
    vpost   = '{1'b1, 1'b1, 1'b0, 32'h7000, 32'h8000, {8{32'h0}},          {8{32'h77777777}}, 1, 1'b0, 1'b0,          1'b0};

    bus.i_read   = 1'b0;
    bus.d_read   = 1'b0;
    bus.d_write  = 1'b0;
    bus.i_addr   = '0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.l2_rdata = '0;
    bus.l2_resp  = 1'b0;
    exp_i_rd     = '0;
    exp_d_rd     = '0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {bus.l2_read, bus.l2_write}, 2'b00);
    chk("rst_resps", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst_l2_addr", bus.l2_addr, '0);
    chk("rst_l2_wdata", bus.l2_wdata, '0);
    chk("rst_i_rdata", bus.i_rdata, '0);
    chk("rst_d_rdata", bus.d_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions, back to back
    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], k != 0);
    end

    // Reset during BUSY_DRD
    bus.i_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_read  = 1'b1;
    bus.d_addr  = 32'h0000_9000;
    tick();
    chk("mid_resp_single", {bus.i_resp, bus.d_resp}, 2'b00);
    tick();
    chk("mid_drd_strobe", {bus.l2_read, bus.l2_write}, 2'b10);
    chk("mid_drd_addr", bus.l2_addr, 32'h0000_9000);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", {bus.l2_read, bus.l2_write}, 2'b00);
    chk("async_rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    #9;
    rst_n      = 1'b1;
    bus.d_read = 1'b0;
    exp_i_rd   = '0;
    exp_d_rd   = '0;
    tick();
    chk("post_rst_strobe", {bus.l2_read, bus.l2_write}, 2'b00);
    // A late L2 completion for the abandoned access must be ignored
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = {8{32'hEEEEEEEE}};
    tick();
    bus.l2_resp = 1'b0;
    chk("late_resp_none", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("late_i_rdata", bus.i_rdata, exp_i_rd);
    chk("late_d_rdata", bus.d_rdata, exp_d_rd);
    tick();
    chk("late_resp_none2", {bus.i_resp, bus.d_resp}, 2'b00);

    // After reset last_grant is D, so the I side wins a tie
    run_vec(vpost, 1'b0);

    // Stray l2_resp in IDLE with no requests
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    tick();
    chk("stray_pre_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = {8{32'hFFFF0000}};
    tick();
    bus.l2_resp = 1'b0;
    chk("stray_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("stray_strobe", {bus.l2_read, bus.l2_write}, 2'b00);
    chk("stray_i_rdata", bus.i_rdata, exp_i_rd);
    chk("stray_d_rdata", bus.d_rdata, exp_d_rd);
    tick();
    chk("stray_resp2", {bus.i_resp, bus.d_resp}, 2'b00);

    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_rr_arbiter.md
Name: l2_rr_arbiter

Overview:
- Shares the single L2 cache port between the I-cache miss path (read-only) and the D-cache miss/writeback path (read and write).
- Arbitrates round-robin and latches the granted request's address and write data.
- Drives one L2 transaction at a time, captures the returned line and routes it back to the winning requester as a one-cycle response.
- Sits between the L1 caches and the L2 cache.

Parameters:
ADDR_W, 32, address width in bits
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache writeback line
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
l2_read  out  1  read strobe to L2, held until l2_resp
l2_write  out  1  write strobe to L2, held until l2_resp
l2_addr  out  ADDR_W  latched address to L2
l2_wdata  out  LINE_W  latched write line to L2
l2_rdata  in  LINE_W  L2 read data, valid with l2_resp
l2_resp  in  1  L2 completion, single cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=D (so I wins the first tie).
  - All strobes and responses are 0.
  - l2_addr, l2_wdata, i_rdata and d_rdata are 0.
- States: IDLE, BUSY_IRD, BUSY_DRD, BUSY_DWR, RESP.
- IDLE:
  - Sample i_read and d_req = d_read|d_write.
  - Only one requester asserted: grant it.
  - Both asserted: grant the side opposite last_grant.
  - On grant, latch addr and d_wdata, update last_grant, and go to the matching BUSY state.
  - If d_read and d_write are both high, write wins (BUSY_DWR).
  - Nothing pending: stay in IDLE.
- BUSY_*:
  - Drive l2_read (IRD/DRD) or l2_write (DWR) from the latched registers.
  - Address and data are stable for the whole transaction; requester input changes are ignored.
  - On l2_resp, capture l2_rdata into the winner's rdata register (reads only) and go to RESP.
- RESP:
  - Exactly one of i_resp/d_resp is high for one cycle, with the rdata register valid.
  - l2_read and l2_write are 0 in RESP.
  - Next state is IDLE unconditionally; requests are not re-sampled in RESP.
- Latency:
  - Request seen in IDLE at cycle 0 gives the L2 strobe at cycle 1.
  - l2_resp at cycle N gives the requester resp at cycle N+1.
  - Best case is 3 cycles request-to-resp with a 1-cycle L2.
- rdata registers hold their value until the next read completion on that side.
- A request arriving during BUSY or RESP waits, and is arbitrated in the next IDLE cycle.
- l2_resp outside a BUSY state is ignored.
- Fairness: with both sides continuously requesting, grants alternate I, D, I, D, …
- Reset mid-transaction: returns to IDLE immediately, with strobes and responses low. The in-flight L2 access is abandoned; L2 is reset concurrently.

Optional Feature:
- Macro: L2_ARB_FIXED_PRIO_EN.
- When defined:
  - Round-robin is disabled and the I-side always wins a tie.
  - last_grant is not implemented.
  - This is the legacy instruction-first policy.
- When undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then i_read=1 with i_addr=0x0000_1000, L2 responds 2 cycles after its strobe with l2_rdata=0xA5…A5 -> l2_read=1 with l2_addr=0x1000 from cycle 1; i_resp=1 for one cycle with i_rdata=0xA5…A5; d_resp stays 0.
- d_write=1, d_addr=0x2000, d_wdata=0x1234…; d_wdata changes to 0 while BUSY -> l2_write=1, l2_wdata holds 0x1234… until l2_resp; d_resp pulses once.
- i_read and d_read both held continuously for 4 transactions -> grant order I, D, I, D; with L2_ARB_FIXED_PRIO_EN it is I, I, I, I.
- d_read and d_write both set -> l2_write=1, l2_read=0.
- rst_n driven low for 1 cycle during BUSY_DRD -> l2_read=0 asynchronously; state is IDLE after release; a later l2_resp produces no d_resp.
- Stray l2_resp in IDLE with no requests -> no i_resp or d_resp; rdata registers unchanged.
